// File: rtl/kyber_decrypt_core_if.sv
// Ciphertext/key bundle in, decoded message out, for kyber_decrypt_core.
// Both directions are valid/ready: a transfer happens on a rising clk edge where valid && ready;
// the producer holds valid and data stable until that edge, and ready may depend on state only.
interface kyber_decrypt_core_if #(
  parameter int N      = 4,
  parameter int K      = 2,
  parameter int COEF_W = 5
);
  logic                     in_valid;
  logic                     in_ready;
  logic [K*N*COEF_W-1:0]    u_in;
  logic [N*COEF_W-1:0]      v_in;
  logic [K*N*COEF_W-1:0]    s_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [N-1:0]             msg_out;
  logic                     busy;

  modport master (
    output in_valid, u_in, v_in, s_in, out_ready,
    input  in_ready, out_valid, msg_out, busy
  );

  modport slave (
    input  in_valid, u_in, v_in, s_in, out_ready,
    output in_ready, out_valid, msg_out, busy
  );
endinterface

// File: rtl/kyber_decrypt_core.sv
// Iterative Kyber-style decryption: w = v - s^T*u in Z_Q[x]/(x^N+1), one MAC per cycle, then 1-bit decode.
// Optional w_out observation port is enabled with `define KYBER_DEC_WOUT_EN.
module kyber_decrypt_core #(
  parameter int Q      = 17,
  parameter int N      = 4,
  parameter int K      = 2,
  parameter int COEF_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  kyber_decrypt_core_if.slave    bus,
`ifdef KYBER_DEC_WOUT_EN
  output logic [N*COEF_W-1:0]    w_out,
`endif
  output logic [1:0]             o_dbg_state
);
  localparam int NW   = (N > 1) ? $clog2(N) : 1;
  localparam int KW   = (K > 1) ? $clog2(K) : 1;
  localparam int PW   = 2 * COEF_W;
  localparam int Q_LO = (Q + 3) / 4;
  localparam int Q_HI = (3 * Q) / 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_SUB  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        r_state;
  logic [COEF_W-1:0] r_u   [K][N];
  logic [COEF_W-1:0] r_s   [K][N];
  logic [COEF_W-1:0] r_v   [N];
  logic [COEF_W-1:0] r_acc [N];
  logic [KW-1:0]     r_k;
  logic [NW-1:0]     r_i;
  logic [NW-1:0]     r_j;
  logic              r_out_valid;
  logic [N-1:0]      r_msg;

  function automatic logic [COEF_W-1:0] mod_q(input logic [PW-1:0] x);
    return COEF_W'(x % PW'(Q));
  endfunction

  logic [PW-1:0]     w_prod;
  logic [COEF_W-1:0] w_p;
  logic [NW:0]       w_sum;
  logic              w_wrap;
  logic [NW-1:0]     w_m;
  logic [COEF_W-1:0] w_acc_cur;
  logic [COEF_W:0]   w_add;
  logic [COEF_W:0]   w_add_r;
  logic [COEF_W:0]   w_sub_t;
  logic [COEF_W-1:0] w_acc_nxt;
  logic              w_last_j;
  logic              w_last_i;
  logic              w_last_k;

  // Product term for (k,i,j); it lands on coefficient (i+j) mod N, negated when x^N wraps.
  always_comb begin
    w_prod    = PW'(r_s[r_k][r_i]) * PW'(r_u[r_k][r_j]);
    w_p       = mod_q(w_prod);
    w_sum     = {1'b0, r_i} + {1'b0, r_j};
    w_wrap    = (w_sum >= (NW+1)'(N));
    w_m       = w_wrap ? NW'(w_sum - (NW+1)'(N)) : NW'(w_sum);
    w_acc_cur = r_acc[w_m];
    w_add     = {1'b0, w_acc_cur} + {1'b0, w_p};
    w_add_r   = (w_add >= (COEF_W+1)'(Q)) ? (w_add - (COEF_W+1)'(Q)) : w_add;
    w_sub_t   = (w_acc_cur >= w_p) ? ({1'b0, w_acc_cur} - {1'b0, w_p})
                                   : ({1'b0, w_acc_cur} + (COEF_W+1)'(Q) - {1'b0, w_p});
    w_acc_nxt = w_wrap ? COEF_W'(w_sub_t) : COEF_W'(w_add_r);
    w_last_j  = (r_j == NW'(N - 1));
    w_last_i  = (r_i == NW'(N - 1));
    w_last_k  = (r_k == KW'(K - 1));
  end

  logic [COEF_W-1:0] w_w [N];
  logic [N-1:0]      w_msg;

  // A coefficient near Q/2 decodes to 1, near 0 (or Q) decodes to 0; both bounds inclusive.
  always_comb begin
    for (int n = 0; n < N; n++) begin
      w_w[n]   = (r_v[n] >= r_acc[n]) ? (r_v[n] - r_acc[n])
                                      : COEF_W'({1'b0, r_v[n]} + (COEF_W+1)'(Q) - {1'b0, r_acc[n]});
      w_msg[n] = (w_w[n] >= COEF_W'(Q_LO)) && (w_w[n] <= COEF_W'(Q_HI));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_out_valid <= 1'b0;
      r_msg       <= '0;
      for (int n = 0; n < N; n++) begin
        r_v[n]   <= '0;
        r_acc[n] <= '0;
      end
      for (int k = 0; k < K; k++) begin
        for (int n = 0; n < N; n++) begin
          r_u[k][n] <= '0;
          r_s[k][n] <= '0;
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            // Operands are reduced on capture so the MAC datapath only ever sees values < Q.
            for (int k = 0; k < K; k++) begin
              for (int n = 0; n < N; n++) begin
                r_u[k][n] <= mod_q(PW'(bus.u_in[(k*N+n)*COEF_W +: COEF_W]));
                r_s[k][n] <= mod_q(PW'(bus.s_in[(k*N+n)*COEF_W +: COEF_W]));
              end
            end
            for (int n = 0; n < N; n++) begin
              r_v[n]   <= mod_q(PW'(bus.v_in[n*COEF_W +: COEF_W]));
              r_acc[n] <= '0;
            end
            r_k     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc[w_m] <= w_acc_nxt;
          if (w_last_j) begin
            r_j <= '0;
            if (w_last_i) begin
              r_i <= '0;
              if (w_last_k) begin
                r_k     <= '0;
                r_state <= S_SUB;
              end else begin
                r_k <= r_k + 1'b1;
              end
            end else begin
              r_i <= r_i + 1'b1;
            end
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        S_SUB: begin
          r_msg       <= w_msg;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef KYBER_DEC_WOUT_EN
  logic [COEF_W-1:0] r_w [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N; n++) r_w[n] <= '0;
    end else if (r_state == S_SUB) begin
      for (int n = 0; n < N; n++) r_w[n] <= w_w[n];
    end
  end

  always_comb begin
    w_out = '0;
    for (int n = 0; n < N; n++) w_out[n*COEF_W +: COEF_W] = r_w[n];
  end
`endif

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.msg_out   = r_msg;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_kyber_decrypt_core.sv
// Directed and randomized bench for kyber_decrypt_core against a polynomial-arithmetic reference model.
module tb_kyber_decrypt_core;
  localparam int Q  = 17;
  localparam int N  = 4;
  localparam int K  = 2;
  localparam int CW = 5;
  localparam int LAT = K * N * N + 1;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  kyber_decrypt_core_if #(.N(N), .K(K), .COEF_W(CW)) bus_if ();

  kyber_decrypt_core #(.Q(Q), .N(N), .K(K), .COEF_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if.slave),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  int tb_u [K][N];
  int tb_s [K][N];
  int tb_v [N];

  logic [N-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: w = v - sum_k s_k * u_k in Z_Q[x]/(x^N+1), then decode near Q/2 to 1.
  function automatic logic [N-1:0] model_msg();
    int w [N];
    logic [N-1:0] m;
    for (int j = 0; j < N; j++) w[j] = tb_v[j] % Q;
    for (int k = 0; k < K; k++)
      for (int a = 0; a < N; a++)
        for (int b = 0; b < N; b++) begin
          int p = (tb_s[k][a] % Q) * (tb_u[k][b] % Q);
          if (a + b < N) w[a+b] -= p;
          else           w[a+b-N] += p;
        end
    m = '0;
    for (int j = 0; j < N; j++) begin
      int r = ((w[j] % Q) + Q) % Q;
      m[j] = (r >= (Q + 3) / 4) && (r <= (3 * Q) / 4);
    end
    return m;
  endfunction

  task automatic randomize_bus();
    bus_if.u_in = {$urandom, $urandom};
    bus_if.s_in = {$urandom, $urandom};
    bus_if.v_in = 20'($urandom);
  endtask

  task automatic drive_arrays();
    for (int k = 0; k < K; k++)
      for (int j = 0; j < N; j++) begin
        bus_if.u_in[(k*N+j)*CW +: CW] = CW'(tb_u[k][j]);
        bus_if.s_in[(k*N+j)*CW +: CW] = CW'(tb_s[k][j]);
      end
    for (int j = 0; j < N; j++) bus_if.v_in[j*CW +: CW] = CW'(tb_v[j]);
  endtask

  // driver: present the bundle, return #1 after the accepting edge
  task automatic send_bundle();
    int guard = 0;
    exp_q.push_back(model_msg());
    @(negedge clk);
    drive_arrays();
    bus_if.in_valid = 1'b1;
    while (!bus_if.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    randomize_bus();
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus_if.out_valid && cyc < 200);
    if (!bus_if.out_valid) check("out_timeout", 0, 1);
  endtask

  task automatic run_bundle(input string tag);
    int cyc;
    logic [N-1:0] exp;
    send_bundle();
    check({tag, "_busy"}, bus_if.busy, 1);
    wait_out(cyc);
    check({tag, "_latency"}, cyc, LAT);
    exp = exp_q.pop_front();
    check({tag, "_msg"}, bus_if.msg_out, exp);
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, bus_if.out_valid, 0);
    check({tag, "_in_ready"}, bus_if.in_ready, 1);
  endtask

  task automatic clear_arrays();
    for (int k = 0; k < K; k++)
      for (int j = 0; j < N; j++) begin
        tb_u[k][j] = 0;
        tb_s[k][j] = 0;
      end
    for (int j = 0; j < N; j++) tb_v[j] = 0;
  endtask

  task automatic random_arrays();
    for (int k = 0; k < K; k++)
      for (int j = 0; j < N; j++) begin
        tb_u[k][j] = $urandom_range(0, 31);
        tb_s[k][j] = $urandom_range(0, 31);
      end
    for (int j = 0; j < N; j++) tb_v[j] = $urandom_range(0, 31);
  endtask

  initial begin
    logic [N-1:0] held;
    int cyc;
    rst_n            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    randomize_bus();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus_if.in_ready, 1);
    check("rst_out_valid", bus_if.out_valid, 0);
    check("rst_msg", bus_if.msg_out, 0);
    check("rst_busy", bus_if.busy, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // s = 0: w = v
    clear_arrays();
    for (int k = 0; k < K; k++)
      for (int j = 0; j < N; j++) tb_u[k][j] = $urandom_range(0, 31);
    tb_v[0] = 9; tb_v[2] = 9;
    check("model_s0", model_msg(), 4'b0101);
    run_bundle("s0_v9");

    clear_arrays();
    tb_v[0] = 4; tb_v[1] = 5; tb_v[2] = 12; tb_v[3] = 13;
    check("model_bound", model_msg(), 4'b0110);
    run_bundle("boundary");

    // x * x^3 = x^4 = -1: acc[0] = -1 = 16, w0 = 8 - 16 = 9
    clear_arrays();
    tb_s[0][1] = 1; tb_u[0][3] = 1; tb_v[0] = 8;
    check("model_wrap", model_msg(), 4'b0001);
    run_bundle("wrap");

    // 18 == 1 mod 17 on every operand
    clear_arrays();
    for (int k = 0; k < K; k++)
      for (int j = 0; j < N; j++) begin
        tb_u[k][j] = 18;
        tb_s[k][j] = 18;
      end
    run_bundle("reduce18");

    for (int t = 0; t < 8; t++) begin
      random_arrays();
      run_bundle($sformatf("rand%0d", t));
    end

    // backpressure with an ignored second bundle
    random_arrays();
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    send_bundle();
    wait_out(cyc);
    check("bp_latency", cyc, LAT);
    held = bus_if.msg_out;
    check("bp_msg", held, exp_q.pop_front());
    for (int c = 0; c < 10; c++) begin
      if (c == 2) begin
        random_arrays();
        drive_arrays();
        bus_if.in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      check($sformatf("bp_hold_valid%0d", c), bus_if.out_valid, 1);
      check($sformatf("bp_hold_msg%0d", c), bus_if.msg_out, held);
      check($sformatf("bp_in_ready%0d", c), bus_if.in_ready, 0);
    end
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", bus_if.out_valid, 0);
    check("bp_release_ready", bus_if.in_ready, 1);
    repeat (40) @(posedge clk);
    #1;
    check("bp_ignored_busy", bus_if.busy, 0);
    check("bp_ignored_valid", bus_if.out_valid, 0);

    // asynchronous abort in the middle of MAC
    random_arrays();
    send_bundle();
    void'(exp_q.pop_front());
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", bus_if.out_valid, 0);
    check("abort_in_ready", bus_if.in_ready, 1);
    check("abort_busy", bus_if.busy, 0);
    check("abort_msg", bus_if.msg_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    random_arrays();
    run_bundle("after_abort");
    clear_arrays();
    tb_v[1] = 9; tb_v[3] = 10;
    run_bundle("after_abort2");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/kyber_decrypt_core.md
Name: kyber_decrypt_core

Overview:
Downstream consumer of the encrypt stage. Takes one ciphertext (vector u of K polynomials, polynomial v) plus the secret key s, and computes w = v − sᵀ·u in Z_Q[x]/(x^N+1). It then decodes each coefficient of w to one message bit.
The block is iterative: one modular multiply-accumulate per cycle. It uses valid/ready handshakes on both input and output.

Parameters:
Q, 17, modulus
N, 4, coefficients per polynomial
K, 2, polynomials per vector
COEF_W, 5, bits per coefficient, must satisfy 2^COEF_W > Q

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  ciphertext/key bundle valid
in_ready  output  1  block can accept a bundle
u_in  input  K*N*COEF_W  u packed; coefficient (k,j) at bits [(k*N+j)*COEF_W +: COEF_W]
v_in  input  N*COEF_W  v packed; coefficient j at bits [j*COEF_W +: COEF_W]
s_in  input  K*N*COEF_W  secret s, packed like u_in
out_valid  output  1  decoded message valid
out_ready  input  1  consumer accepts message
msg_out  output  N  decoded message, bit j from w[j]
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset:
  - state IDLE, in_ready 1, out_valid 0, msg_out 0, busy 0.
  - Accumulators, counters and captured operands are all cleared.
  - Reset asserted mid-operation aborts the operation immediately. No partial result is ever presented.
- States: IDLE → MAC → SUB → DONE → IDLE.
- in_ready = (state==IDLE). This is combinational from state.
- IDLE:
  - On edge with in_valid&&in_ready: capture u, v, s, each coefficient reduced mod Q (inputs ≥Q are legal).
  - Clear acc[0..N-1] and counters k=i=j=0, then go to MAC.
- MAC: one product per cycle, K*N*N cycles (32 at defaults).
  - Loop order: j innermost, then i, then k.
  - p = s[k][i]*u[k][j] mod Q, with m = (i+j) mod N.
  - If i+j < N: acc[m] = (acc[m]+p) mod Q. Otherwise acc[m] = (acc[m]−p+Q) mod Q (negacyclic wrap).
  - acc stays in [0,Q−1] at all times; no wide accumulation.
  - After the last (k,i,j)=(K−1,N−1,N−1) product, go to SUB.
- SUB (1 cycle):
  - w[j] = (v[j] − acc[j] + Q) mod Q.
  - msg_out[j] = 1 iff Q_LO ≤ w[j] ≤ Q_HI, where Q_LO=(Q+3)/4 and Q_HI=(3*Q)/4 (integer division). At Q=17 this gives 5 and 12.
  - Register msg_out, set out_valid=1, go to DONE.
- DONE:
  - Hold out_valid and msg_out stable while out_ready=0.
  - On out_valid&&out_ready edge: out_valid→0, go to IDLE.
  - msg_out retains its last value until the next SUB.
- Latency: acceptance at edge T, out_valid high after edge T+K*N*N+1 (T+33 at defaults).
- Throughput: one bundle per K*N*N+3 cycles minimum, with out_ready tied high.
- in_valid while busy is ignored (in_ready=0). Inputs do not need to be held after acceptance.
- Multiplier width is 2*COEF_W. Reduce mod Q before add/sub.

Optional Feature:
Macro KYBER_DEC_WOUT_EN.
- Defined:
  - Adds output port w_out, N*COEF_W bits, packed like v_in.
  - w_out is registered in SUB together with msg_out, resets to 0, and is held through DONE.
  - Used for decryption-failure and noise-margin analysis.
- Undefined: no w_out port and no w registers. msg_out behaviour is identical in both builds.

Test Plan:
- s=0, v=[9,0,9,0] (index 0 first), u arbitrary → msg_out=4'b0101, out_valid exactly 33 cycles after the accept edge.
- s=0, v=[4,5,12,13] → w=v, msg_out=4'b0110 (decision boundaries at 5 and 12 both inclusive).
- Negacyclic wrap: s[0]=[0,1,0,0], u[0]=[0,0,0,1], s[1]=u[1]=0, v=[8,0,0,0] → acc[0]=16, w=[9,0,0,0], msg_out=4'b0001; with KYBER_DEC_WOUT_EN, w_out coefficient0=9.
- Reduction on capture: all u,s coefficients=18 (≡1), v=0 → each acc[m] = 2×(count of non-wrapping minus wrapping terms) mod 17; check against a reference model.
- Backpressure: out_ready=0 for 10 cycles after out_valid → msg_out stable, in_ready=0, and a second in_valid is ignored; release → out_valid drops next edge, in_ready=1.
- rst_n pulsed low at MAC cycle 10 → out_valid=0, in_ready=1 immediately (async). The next bundle then produces the correct result with no residue from the aborted operation.
